// File: rtl/pipelined_extend_adder_if.sv
// Operand/sum handshake bundle for pipelined_extend_adder.
// The master drives operands and out_ready; the adder is the slave.
interface pipelined_extend_adder_if #(
  parameter int A_WIDTH = 58,
  parameter int B_WIDTH = 55
);
  logic               in_valid;
  logic               in_ready;
  logic [A_WIDTH-1:0] a;
  logic [B_WIDTH-1:0] b;
  logic               b_sext;
  logic               out_valid;
  logic               out_ready;
  logic [A_WIDTH:0]   sum;

  modport master (output in_valid, a, b, b_sext, out_ready,
                  input  in_ready, out_valid, sum);
  modport slave  (input  in_valid, a, b, b_sext, out_ready,
                  output in_ready, out_valid, sum);
endinterface

// File: rtl/pipelined_extend_adder.sv
// Unequal-width adder with B zero/sign extension, carry chain split into
// CHUNK-bit registered stages under a single global advance.
module pipelined_extend_adder_stage #(
  parameter int A_WIDTH = 58,
  parameter int LO      = 0,
  parameter int W       = 20
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               adv,
  input  logic               vld_i,
  input  logic [W-1:0]       a_i,
  input  logic [W-1:0]       b_i,
  input  logic [A_WIDTH-1:0] s_i,
  input  logic               c_i,
  output logic               vld_o,
  output logic [A_WIDTH-1:0] s_o,
  output logic               c_o
);
  logic [W:0]         part;
  logic [A_WIDTH-1:0] s_nx;

  assign part = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, c_i};

  always_comb begin
    s_nx         = s_i;
    s_nx[LO+:W]  = part[W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)   vld_o <= 1'b0;
    else if (adv) vld_o <= vld_i;

  // Datapath needs no reset: it is only observed behind vld_o.
  always_ff @(posedge clk)
    if (adv) begin
      s_o <= s_nx;
      c_o <= part[W];
    end
endmodule

module pipelined_extend_adder #(
  parameter int A_WIDTH = 58,
  parameter int B_WIDTH = 55,
  parameter int CHUNK   = 20
) (
  input  logic clk,
  input  logic rst_n,
  pipelined_extend_adder_if.slave bus
);
  localparam int STAGES = (A_WIDTH + CHUNK - 1) / CHUNK;

  logic               adv;
  logic [STAGES:0]    vld_pipe;
  logic [A_WIDTH-1:0] b_ext;
  logic [A_WIDTH-1:0] a_q [STAGES];
  logic [A_WIDTH-1:0] b_q [STAGES];
  logic [A_WIDTH-1:0] s_q [STAGES];
  logic               c_q [STAGES];

  assign adv           = !vld_pipe[STAGES] | bus.out_ready;
  assign bus.in_ready  = adv;
  assign vld_pipe[0]   = bus.in_valid;
  assign bus.out_valid = vld_pipe[STAGES];
  assign bus.sum       = vld_pipe[STAGES] ? {c_q[STAGES-1], s_q[STAGES-1]} : '0;

  // Extend once at the input so the mode bit never travels down the pipe.
  always_comb begin
    b_ext = A_WIDTH'(bus.b);
    if (bus.b_sext && bus.b[B_WIDTH-1]) b_ext = b_ext | ({A_WIDTH{1'b1}} << B_WIDTH);
  end

  always_ff @(posedge clk)
    if (adv) begin
      a_q[0] <= bus.a;
      b_q[0] <= b_ext;
      for (int k = 1; k < STAGES; k++) begin
        a_q[k] <= a_q[k-1];
        b_q[k] <= b_q[k-1];
      end
    end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = k * CHUNK;
    localparam int W  = (A_WIDTH - LO < CHUNK) ? (A_WIDTH - LO) : CHUNK;
    logic [W-1:0]       a_i, b_i;
    logic [A_WIDTH-1:0] s_i;
    logic               c_i;

    if (k == 0) begin : g_first
      assign a_i = bus.a[LO+:W];
      assign b_i = b_ext[LO+:W];
      assign s_i = '0;
      assign c_i = 1'b0;
    end else begin : g_next
      assign a_i = a_q[k-1][LO+:W];
      assign b_i = b_q[k-1][LO+:W];
      assign s_i = s_q[k-1];
      assign c_i = c_q[k-1];
    end

    pipelined_extend_adder_stage #(.A_WIDTH(A_WIDTH), .LO(LO), .W(W)) u_stage (
      .clk   (clk),
      .rst_n (rst_n),
      .adv   (adv),
      .vld_i (vld_pipe[k]),
      .a_i   (a_i),
      .b_i   (b_i),
      .s_i   (s_i),
      .c_i   (c_i),
      .vld_o (vld_pipe[k+1]),
      .s_o   (s_q[k]),
      .c_o   (c_q[k])
    );
  end
endmodule
